// File: rtl/uart_tx_fifo_pkg.sv
// Shared definitions for the uart transmit FIFO: byte width, dispatch FSM states
// and the count-width helper used by the interface and the top.
package uart_tx_fifo_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_WAIT = 2'd2
  } tx_state_e;

  // count spans 0..DEPTH inclusive, so it needs one bit more than a pointer
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Host push side plus uart_tx handshake side of the transmit FIFO.
interface uart_tx_fifo_if
  import uart_tx_fifo_pkg::*;
#(
  parameter int DEPTH = 16
);
  localparam int CW = cnt_w(DEPTH);

  logic [BYTE_W-1:0] wr_data;
  logic              wr_en;
  logic              flush;
  logic              full;
  logic              empty;
  logic [CW-1:0]     count;
  logic              overflow;
  logic [BYTE_W-1:0] tx_data;
  logic              tx_send;
  logic              tx_ready;
  logic              busy;

  modport master (
    output wr_data, wr_en, flush, tx_ready,
    input  full, empty, count, overflow, tx_data, tx_send, busy
  );

  modport slave (
    input  wr_data, wr_en, flush, tx_ready,
    output full, empty, count, overflow, tx_data, tx_send, busy
  );

endinterface

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with occupancy count, overflow pulse and synchronous flush.
// Read data is mem[rd_ptr] combinationally; a push is visible one cycle later.
module uart_sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   wr_en,
  input  logic                   rd_en,
  input  logic                   flush,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [ADDR_W-1:0]           wr_ptr, rd_ptr;
  logic                        do_push, do_pop;

  // flush beats everything: a coincident push is dropped silently
  assign do_push  = wr_en & ~full & ~flush;
  assign do_pop   = rd_en & ~empty & ~flush;
  assign overflow = wr_en & full & ~flush;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + ADDR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (ADDR_W+1)'(1);
        2'b01:   count <= count - (ADDR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Transmit FIFO and dispatch FSM feeding uart_tx's data/send/ready handshake.
// ready arrives from the clk_uart side, so every FSM decision uses its 2-flop copy.
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input logic          clk,
  input logic          rst_n,
  uart_tx_fifo_if.slave bus
);
  localparam int CW = cnt_w(DEPTH);

  tx_state_e         state;
  logic [1:0]        rdy_pipe;
  logic              rdy_s;
  logic              pop;
  logic [BYTE_W-1:0] fifo_rd;
  logic [BYTE_W-1:0] tx_data_q;
  logic              tx_send_q;
  logic              fifo_empty;
  logic [CW-1:0]     fifo_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdy_pipe <= '0;
    else        rdy_pipe <= {rdy_pipe[0], bus.tx_ready};
  end
  assign rdy_s = rdy_pipe[1];

  assign pop = (state == ST_IDLE) & ~fifo_empty & rdy_s;

  uart_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (BYTE_W)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_data  (bus.wr_data),
    .wr_en    (bus.wr_en),
    .rd_en    (pop),
    .flush    (bus.flush),
    .rd_data  (fifo_rd),
    .full     (bus.full),
    .empty    (fifo_empty),
    .count    (fifo_count),
    .overflow (bus.overflow)
  );

  // tx_send rises one cycle into SEND and drops as soon as uart_tx leaves READY,
  // so a new frame never starts before the previous one finished its stop bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      tx_data_q <= '0;
      tx_send_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          tx_send_q <= 1'b0;
          if (pop) begin
            tx_data_q <= fifo_rd;
            state     <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (!rdy_s) begin
            tx_send_q <= 1'b0;
            state     <= ST_WAIT;
          end else begin
            tx_send_q <= 1'b1;
          end
        end
        ST_WAIT: begin
          tx_send_q <= 1'b0;
          if (rdy_s) state <= ST_IDLE;
        end
        default: begin
          tx_send_q <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.tx_data = tx_data_q;
  assign bus.tx_send = tx_send_q;
  assign bus.empty   = fifo_empty;
  assign bus.count   = fifo_count;
  assign bus.busy    = (state != ST_IDLE) | ~fifo_empty;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: table-driven FIFO vectors, hand sequences for latency,
// reset and flush, and a randomized run checked against a queue-based reference.
module tb_uart_tx_fifo;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_tx_fifo_if #(.DEPTH(DEPTH)) bus ();

  uart_tx_fifo #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  // downstream uart_tx stand-in: holds ready low for one frame after seeing send
  bit         uart_on   = 1'b1;
  logic       man_ready = 1'b0;
  logic       m_ready   = 1'b1;
  int         m_st      = 0;
  int         m_cnt     = 0;
  int         frame_len = 30;
  logic [7:0] m_cap     = '0;
  bit         m_bad     = 1'b0;
  logic [7:0] got[$];

  assign bus.tx_ready = uart_on ? m_ready : man_ready;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_st    <= 0;
      m_cnt   <= 0;
      m_ready <= 1'b1;
    end else if (uart_on) begin
      case (m_st)
        0: if (bus.tx_send) begin m_st <= 1; m_cnt <= 2; end
        1: if (m_cnt == 1) begin
             m_ready <= 1'b0; m_cap <= bus.tx_data; m_cnt <= frame_len; m_st <= 2;
           end else m_cnt <= m_cnt - 1;
        default: begin
          if (bus.tx_data !== m_cap) m_bad <= 1'b1;
          if (m_cnt == 1) begin
            m_ready <= 1'b1; got.push_back(m_cap); m_st <= 0;
          end else m_cnt <= m_cnt - 1;
        end
      endcase
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
  endtask

  task automatic wait_got(input int n, input int budget, input string name);
    int k = 0;
    while (got.size() < n && k < budget) begin @(posedge clk); #1; k++; end
    chk(name, got.size(), n);
  endtask

  task automatic wait_send(input int budget, input string name);
    int k = 0;
    while (bus.tx_send !== 1'b1 && k < budget) begin @(posedge clk); #1; k++; end
    chk(name, bus.tx_send, 1);
  endtask

  task automatic wait_idle(input int budget, input string name);
    int k = 0;
    while ((bus.busy !== 1'b0 || m_st != 0) && k < budget) begin @(posedge clk); #1; k++; end
    chk(name, bus.busy, 0);
  endtask

  task automatic push(input logic [7:0] d);
    bus.wr_data = d; bus.wr_en = 1'b1;
    @(posedge clk); #1;
    bus.wr_en = 1'b0;
  endtask

  typedef struct {
    logic       wr_en;
    logic       flush;
    logic [7:0] d;
    logic       ovf;
    logic [4:0] cnt;
    logic       full;
    logic       empty;
  } vec_t;
  vec_t tv[$];

  task automatic apply_vecs(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      bus.wr_en = tv[i].wr_en; bus.flush = tv[i].flush; bus.wr_data = tv[i].d;
      @(negedge clk);
      chk($sformatf("vec%0d_ovf", i), bus.overflow, tv[i].ovf);
      @(posedge clk); #1;
      chk($sformatf("vec%0d_cnt", i), bus.count, tv[i].cnt);
      chk($sformatf("vec%0d_full", i), bus.full, tv[i].full);
      chk($sformatf("vec%0d_empty", i), bus.empty, tv[i].empty);
    end
    bus.wr_en = 1'b0; bus.flush = 1'b0;
  endtask

  logic [7:0] exp_q[$];
  logic [9:0] line;
  int pushed, sends, k;
  logic prev_send;

  initial begin
    bus.wr_data = '0; bus.wr_en = 1'b0; bus.flush = 1'b0;

    // rows 0..17: fill to full with 01..10, one dropped push, one idle cycle
    for (int i = 0; i < DEPTH; i++)
      tv.push_back('{1'b1, 1'b0, 8'(i + 1), 1'b0, 5'(i + 1), (i == DEPTH - 1), 1'b0});
    tv.push_back('{1'b1, 1'b0, 8'hFF, 1'b1, 5'd16, 1'b1, 1'b0});
    tv.push_back('{1'b0, 1'b0, 8'h00, 1'b0, 5'd16, 1'b1, 1'b0});
    // rows 18..22: flush while pushing drops the push without overflow
    tv.push_back('{1'b1, 1'b0, 8'h11, 1'b0, 5'd1, 1'b0, 1'b0});
    tv.push_back('{1'b1, 1'b0, 8'h22, 1'b0, 5'd2, 1'b0, 1'b0});
    tv.push_back('{1'b1, 1'b0, 8'h33, 1'b0, 5'd3, 1'b0, 1'b0});
    tv.push_back('{1'b1, 1'b1, 8'h44, 1'b0, 5'd0, 1'b0, 1'b1});
    tv.push_back('{1'b1, 1'b0, 8'h55, 1'b0, 5'd1, 1'b0, 1'b0});

    // reset state
    #2;
    chk("rst_count", bus.count, 0);
    chk("rst_empty", bus.empty, 1);
    chk("rst_full", bus.full, 0);
    chk("rst_ovf", bus.overflow, 0);
    chk("rst_send", bus.tx_send, 0);
    chk("rst_data", bus.tx_data, 0);
    chk("rst_busy", bus.busy, 0);
    cyc(2);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    cyc(3);

    // single byte latency and frame contents
    bus.wr_data = 8'hA5; bus.wr_en = 1'b1;
    @(posedge clk); #1; bus.wr_en = 1'b0;
    chk("lat_e0", bus.tx_send, 0);
    @(posedge clk); #1;
    chk("lat_e1", bus.tx_send, 0);
    @(posedge clk); #1;
    chk("lat_e2", bus.tx_send, 1);
    chk("lat_data", bus.tx_data, 8'hA5);
    wait_got(1, 200, "single_got");
    if (got.size() > 0) begin
      line = {1'b1, got[0], 1'b0};
      chk("single_line", line, 10'b1101001010);
    end
    wait_idle(100, "single_idle");

    // async reset in the middle of SEND with a byte still queued
    got.delete();
    push(8'h3C); push(8'h3D);
    wait_send(50, "rst_mid_send_seen");
    chk("rst_mid_cnt_before", bus.count, 1);
    rst_n = 1'b0; #1;
    chk("rst_mid_send", bus.tx_send, 0);
    chk("rst_mid_empty", bus.empty, 1);
    chk("rst_mid_count", bus.count, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    cyc(3);
    chk("rst_mid_idle", bus.busy, 0);

    // burst fill and overflow with ready held low, then drain in order
    uart_on = 1'b0; man_ready = 1'b0;
    cyc(3);
    got.delete();
    apply_vecs(0, 17);
    uart_on = 1'b1;
    wait_got(DEPTH, DEPTH * 60, "burst_got");
    for (int i = 0; i < DEPTH && i < got.size(); i++)
      chk($sformatf("burst_byte%0d", i), got[i], 8'(i + 1));
    wait_idle(100, "burst_idle");
    chk("burst_no_ff", got.size(), DEPTH);

    // flush with coincident push, then only the later byte is sent
    uart_on = 1'b0; man_ready = 1'b0;
    cyc(3);
    got.delete();
    apply_vecs(18, 22);
    uart_on = 1'b1;
    wait_got(1, 200, "flushtab_got");
    wait_idle(100, "flushtab_idle");
    chk("flushtab_n", got.size(), 1);
    if (got.size() > 0) chk("flushtab_byte", got[0], 8'h55);

    // flush while byte 1 is in flight
    got.delete();
    for (int i = 0; i < 5; i++) push(8'hA1 + 8'(i));
    wait_send(50, "flushmid_seen");
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    chk("flushmid_count", bus.count, 0);
    chk("flushmid_empty", bus.empty, 1);
    wait_idle(200, "flushmid_idle");
    chk("flushmid_n", got.size(), 1);
    if (got.size() > 0) chk("flushmid_byte", got[0], 8'hA1);

    // randomized sustained traffic, 7E2-length frames, >2*DEPTH bytes
    frame_len = 22;
    got.delete(); exp_q.delete();
    pushed = 0; sends = 0; k = 0; prev_send = 1'b0;
    while (pushed < 40 && k < 4000) begin
      if (bus.tx_send && !prev_send) sends++;
      prev_send = bus.tx_send;
      chk("rand_cnt_le_depth", (bus.count <= 5'(DEPTH)), 1);
      if ((pushed - sends) < DEPTH && $urandom_range(0, 1) == 1) begin
        bus.wr_data = 8'($urandom);
        bus.wr_en = 1'b1;
        exp_q.push_back(bus.wr_data);
        pushed++;
      end else bus.wr_en = 1'b0;
      @(negedge clk);
      chk("rand_no_ovf", bus.overflow, 0);
      @(posedge clk); #1;
      k++;
    end
    bus.wr_en = 1'b0;
    chk("rand_pushed", pushed, 40);
    wait_got(exp_q.size(), 40 * 40, "rand_got");
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      chk($sformatf("rand_byte%0d", i), got[i], exp_q[i]);
    wait_idle(200, "rand_idle");
    chk("data_stable_in_frame", m_bad, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
